// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencing for the single-cycle
// LEGv8 datapath. Computes the next PC for sequential flow, B and CBZ. When
// the PC_FETCH_CBNZ_EN macro is defined, CBNZ is also recognised as a branch.
// The unit holds on stall and halts once the PC leaves the program region.
// It also keeps a count of retired instructions.
module pc_fetch_unit #(
  parameter logic [63:0] PC_LIMIT = 64'd60,
  parameter int unsigned COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [31:0]        Instr,
  input  logic               Zero,
  output logic [63:0]        Pc,
  output logic [63:0]        PcPlus4,
  output logic               BranchTaken,
  output logic               Halted,
  output logic [COUNT_W-1:0] InstrCount
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state_q;
  logic [63:0]        pc_q;
  logic [COUNT_W-1:0] count_q;
  logic               halted_q;

  logic        is_b;
  logic        is_cbz;
  logic        is_cbnz;
  logic        taken_raw;
  logic [63:0] offset;
  logic [63:0] target;
  logic [63:0] next_pc;

  // Instr[4:0] names the tested register; this stage does not need it.
  logic unused_rt;
  assign unused_rt = ^Instr[4:0];

  // Decode the branch class and build the byte offset of the branch.
  always_comb begin
    is_b   = (Instr[31:26] == 6'b000101);
    is_cbz = (Instr[31:24] == 8'b10110100);
`ifdef PC_FETCH_CBNZ_EN
    is_cbnz = (Instr[31:24] == 8'b10110101);
`else
    is_cbnz = 1'b0;
`endif
    taken_raw = is_b | (is_cbz & Zero) | (is_cbnz & ~Zero);
    if (is_b) begin
      offset = {{36{Instr[25]}}, Instr[25:0], 2'b00};
    end else begin
      offset = {{43{Instr[23]}}, Instr[23:5], 2'b00};
    end
  end

  // Compute the next-PC mux. Once halted, the branch indication is suppressed.
  always_comb begin
    PcPlus4     = pc_q + 64'd4;
    target      = pc_q + offset;
    BranchTaken = taken_raw & (state_q == RUN);
    next_pc     = BranchTaken ? target : PcPlus4;
  end

  // Fetch FSM. Stall takes priority over the halt check, and reset overrides
  // everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            pc_q    <= next_pc;
            count_q <= count_q + 1'b1;
            if (next_pc >= PC_LIMIT) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end
        end
        HALT: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign Pc         = pc_q;
  assign Halted     = halted_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. It runs directed program scenarios first, then
// randomized branch and stall traffic. Expected results come from a reference
// model, pass through a queue, and are checked by a separate monitor.
module tb_pc_fetch_unit;

  localparam logic [63:0] LIMIT = 64'd60;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] Instr;
  logic        Zero;
  logic [63:0] Pc;
  logic [63:0] PcPlus4;
  logic        BranchTaken;
  logic        Halted;
  logic [31:0] InstrCount;

  pc_fetch_unit #(.PC_LIMIT(LIMIT), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .Instr(Instr), .Zero(Zero),
    .Pc(Pc), .PcPlus4(PcPlus4), .BranchTaken(BranchTaken), .Halted(Halted),
    .InstrCount(InstrCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        comb_ok;
    logic        bt;
    logic [63:0] pc4;
    logic [63:0] pc;
    logic [31:0] cnt;
    logic        halt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  bit   drv_done = 0;

  // Reference model state
  logic [63:0] m_pc    = '0;
  logic [31:0] m_cnt   = '0;
  logic        m_halt  = 1'b0;
  logic        m_known = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic m_is_branch(input logic [31:0] ins, input logic z);
    if (ins[31:26] == 6'b000101) return 1'b1;
    if (ins[31:24] == 8'hB4) return z;
`ifdef PC_FETCH_CBNZ_EN
    if (ins[31:24] == 8'hB5) return !z;
`endif
    return 1'b0;
  endfunction

  // Signed byte offset of the branch, computed with plain integer arithmetic.
  function automatic longint m_off(input logic [31:0] ins);
    longint v;
    if (ins[31:26] == 6'b000101) begin
      v = longint'(ins[25:0]);
      if (v >= 64'sd33554432) v = v - 64'sd67108864;
    end else begin
      v = longint'(ins[23:5]);
      if (v >= 64'sd262144) v = v - 64'sd524288;
    end
    return v * 4;
  endfunction

  function automatic logic [31:0] mk_b(input int words);
    logic [25:0] f;
    f = 26'(words);
    return {6'b000101, f};
  endfunction

  function automatic logic [31:0] mk_cb(input logic nz, input int words);
    logic [18:0] f;
    logic [4:0]  rt;
    f  = 19'(words);
    rt = 5'($urandom);
    return {7'b1011010, nz, f, rt};
  endfunction

  function automatic logic [31:0] mk_alu();
    logic [20:0] lo;
    lo = 21'($urandom);
    case ($urandom_range(0, 2))
      0:       return {11'h458, lo};  // ADD
      1:       return {11'h7C2, lo};  // LDUR
      default: return {11'h7C0, lo};  // STUR
    endcase
  endfunction

  // Drive one cycle of stimulus and queue the model's prediction for it.
  task automatic step(input logic rst, input logic stl, input logic [31:0] ins, input logic z);
    exp_t        e;
    logic [63:0] nxt;
    logic [63:0] offv;
    @(negedge clk);
    #1;
    reset = rst; stall = stl; Instr = ins; Zero = z;
    e.comb_ok = m_known;
    e.bt      = !m_halt && m_is_branch(ins, z);
    e.pc4     = m_pc + 64'd4;
    if (rst) begin
      m_pc = '0; m_cnt = '0; m_halt = 1'b0; m_known = 1'b1;
    end else if (!m_halt && !stl) begin
      offv = m_off(ins);
      nxt  = e.bt ? (m_pc + offv) : (m_pc + 64'd4);
      m_pc  = nxt;
      m_cnt = m_cnt + 1;
      if (nxt >= LIMIT) m_halt = 1'b1;
    end
    e.pc = m_pc; e.cnt = m_cnt; e.halt = m_halt;
    q.push_back(e);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, mk_alu(), 1'($urandom));
  endtask

  // Check the DUT directly against constants worked out from the program scenarios.
  task automatic direct(input string nm, input logic [63:0] pc_exp, input logic [31:0] cnt_exp, input logic h_exp);
    @(posedge clk);
    #2;
    chk({nm, ".Pc"}, Pc, pc_exp);
    chk({nm, ".InstrCount"}, 64'(InstrCount), 64'(cnt_exp));
    chk({nm, ".Halted"}, 64'(Halted), 64'(h_exp));
  endtask

  // Monitor: pops each prediction and checks combinational outputs before the
  // edge and registered outputs after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.comb_ok) begin
          chk("BranchTaken", 64'(BranchTaken), 64'(e.bt));
          chk("PcPlus4", PcPlus4, e.pc4);
        end
        @(posedge clk);
        #1;
        chk("Pc", Pc, e.pc);
        chk("InstrCount", 64'(InstrCount), 64'(e.cnt));
        chk("Halted", 64'(Halted), 64'(e.halt));
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1; stall = 1'b0; Instr = '0; Zero = 1'b0;

    // Reset, then sequential flow into a forward CBZ and a backward B.
    step(1'b1, 1'b0, 32'hB40000BF, 1'b1);
    direct("reset", 64'd0, 32'd0, 1'b0);
    nops(6);
    direct("seq6", 64'd24, 32'd6, 1'b0);
    step(1'b0, 1'b0, 32'hB40000BF, 1'b1);
    direct("cbz_taken", 64'd44, 32'd7, 1'b0);
    step(1'b0, 1'b0, 32'h17FFFFFF, 1'b0);
    direct("b_back", 64'd40, 32'd8, 1'b0);

    // CBZ not taken.
    step(1'b1, 1'b0, mk_alu(), 1'b0);
    nops(6);
    step(1'b0, 1'b0, 32'hB40000BF, 1'b0);
    direct("cbz_not", 64'd28, 32'd7, 1'b0);

    // Stall at 16, then stall at 56 with no halt until the stall drops.
    step(1'b1, 1'b0, mk_alu(), 1'b0);
    nops(4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hB40000BF, 1'b1);
    direct("stall16", 64'd16, 32'd4, 1'b0);
    nops(10);
    step(1'b0, 1'b1, mk_alu(), 1'b0);
    direct("stall56", 64'd56, 32'd14, 1'b0);
    nops(1);
    direct("halt60", 64'd60, 32'd15, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h17FFFFFF, 1'b0);
    direct("halt_frozen", 64'd60, 32'd15, 1'b1);
    step(1'b1, 1'b1, 32'h17FFFFFF, 1'b0);
    direct("halt_reset", 64'd0, 32'd0, 1'b0);

    // Backward branch from 0 wraps around and halts.
    step(1'b0, 1'b0, 32'h17FFFFFF, 1'b0);
    direct("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'd1, 1'b1);

    // CBNZ at 24 with Zero=0.
    step(1'b1, 1'b0, mk_alu(), 1'b0);
    nops(6);
    step(1'b0, 1'b0, 32'hB50000BF, 1'b0);
`ifdef PC_FETCH_CBNZ_EN
    direct("cbnz", 64'd44, 32'd7, 1'b0);
`else
    direct("cbnz", 64'd28, 32'd7, 1'b0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic        rst, stl, z;
      logic [31:0] ins;
      int          off;
      rst = ($urandom_range(0, 99) < 4);
      stl = ($urandom_range(0, 4) == 0);
      z   = 1'($urandom);
      off = $urandom_range(0, 10) - 5;
      if ($urandom_range(0, 19) == 0) off = int'($urandom);
      case ($urandom_range(0, 3))
        0:       ins = mk_b(off);
        1:       ins = mk_cb(1'b0, off);
        2:       ins = mk_cb(1'b1, off);
        default: ins = mk_alu();
      endcase
      step(rst, stl, ins, z);
    end

    drv_done = 1;
    budget = 0;
    while (q.size() > 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (q.size() > 0) $display("FAIL drain: %0d items left, required 0", q.size());
    else passed++;
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle LEGv8 datapath. It sits directly upstream of the byte-addressed instruction memory, driving its 64-bit `Pc` input and consuming the 32-bit instruction word returned in the same cycle. It computes the next PC for sequential flow, `B`, and `CBZ` (plus `CBNZ` when configured), holds on stall, and halts when the PC leaves the loaded program region. It also maintains a retired-instruction counter.

## Interface
Parameters:
- `PC_LIMIT`, default 64'd60: first byte address outside the program; reaching it or beyond halts fetch.
- `COUNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hold the PC and the counter this cycle.
- `Instr` input 32: instruction word returned by instruction memory for the current `Pc`.
- `Zero` input 1: ALU zero flag for the current instruction's register test.
- `Pc` output 64: current fetch address, driven to instruction memory.
- `PcPlus4` output 64: `Pc + 4`, combinational.
- `BranchTaken` output 1: combinational; the current instruction redirects the PC.
- `Halted` output 1: registered; fetch has stopped.
- `InstrCount` output `COUNT_W`: number of instructions retired since reset.

## Operation
- States: `RUN` and `HALT`. `Halted` = (state == `HALT`).
- Decode from `Instr`:
  - `B`: `Instr[31:26]==6'b000101`, offset `imm26 = Instr[25:0]`.
  - `CBZ`: `Instr[31:24]==8'b10110100`, offset `imm19 = Instr[23:5]`.
- Branch taken: `B` unconditionally; `CBZ` when `Zero==1`.
- Target = `Pc + (sign_extend(imm) << 2)`, computed at 64 bits; arithmetic is modulo 2^64, so wrap-around is allowed. Negative offsets wrap to high addresses.
- `NextPc` = target if `BranchTaken`, else `PcPlus4`.
- In `RUN` with `stall==0`:
  - `Pc <= NextPc`.
  - `InstrCount <= InstrCount + 1`, wrapping at 2^`COUNT_W`.
  - If `NextPc >= PC_LIMIT` (unsigned), the state goes to `HALT`. This also covers wrapped negative targets.
- In `RUN` with `stall==1`: all registers hold. Stall takes priority over the halt check.
- `HALT` is absorbing. `Pc` and `InstrCount` freeze and `BranchTaken` is forced to 0. Only `reset` leaves `HALT`.
- Outside `HALT`, `BranchTaken` is always driven from the current `Instr`, even during a stall.
- Unrecognised opcodes (ALU, LDUR, STUR) take `PcPlus4`.

## Timing
- Reset values: `Pc`=0, `InstrCount`=0, state `RUN`, `Halted`=0. `BranchTaken` follows `Instr` combinationally from reset.
- `reset` overrides `stall`, halt, and any branch in the same cycle, including mid-program and while in `HALT`.
- Latency:
  - `Pc` → `Instr` → `BranchTaken`/`NextPc` is purely combinational within one cycle.
  - `Pc` updates one edge after an instruction is presented.
- `Halted` asserts on the same edge that loads the out-of-range `Pc`.
- `InstrCount` counts the instruction whose `NextPc` triggered the halt.
- No handshake with instruction memory: `Instr` is valid in the cycle `Pc` is driven.

## Configuration
- `PC_FETCH_CBNZ_EN`:
  - Defined: `CBNZ` (`Instr[31:24]==8'b10110101`, imm19 as for `CBZ`) is a conditional branch, taken when `Zero==0`.
  - Undefined: that opcode is treated as non-branch and takes `PcPlus4`.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert `reset` with `stall=0` and `Instr=32'hB40000BF`, `Zero=1` → after the edge, `Pc`=0, `InstrCount`=0, `Halted`=0. Deassert, present non-branch words for 6 edges → `Pc`=24, `InstrCount`=6.
- CBZ taken: at `Pc`=24, `Instr=32'hB40000BF`, `Zero=1` → `BranchTaken`=1, next `Pc`=44. Repeat with `Zero=0` → next `Pc`=28.
- Backward B: at `Pc`=44, `Instr=32'h17FFFFFF` (offset −1) → next `Pc`=40. At `Pc`=0, `Instr=32'h17FFFFFF` → `Pc` wraps to 64'hFFFF_FFFF_FFFF_FFFC and `Halted`=1.
- Halt: sequential flow from `Pc`=56 → `Pc`=60, `Halted`=1. Further edges with a branch word → `Pc` stays 60, `BranchTaken`=0, `InstrCount` frozen. `reset` → `Pc`=0, `Halted`=0.
- Stall: `stall=1` for 3 edges at `Pc`=16 → `Pc`=16 and `InstrCount` unchanged. At `Pc`=56 with `stall=1` → no halt until `stall` drops.
- CBNZ: `Instr=32'hB50000BF` at `Pc`=24 with `Zero=0`:
  - With `PC_FETCH_CBNZ_EN` defined → next `Pc`=44.
  - Without it → next `Pc`=28.
